// File: rtl/mac_kbd_host_if.sv
// Byte-level command/response channel between the Mac-side host and the keyboard.
// The host drives commands and the keyboard drives responses. Each byte is valid while its
// strobe is high.
interface mac_kbd_host_if;
  logic [7:0] cmd_data;
  logic       cmd_strobe;
  logic [7:0] rsp_data;
  logic       rsp_strobe;

  modport master (
    output cmd_data,
    output cmd_strobe,
    input  rsp_data,
    input  rsp_strobe
  );

  modport slave (
    input  cmd_data,
    input  cmd_strobe,
    output rsp_data,
    output rsp_strobe
  );
endinterface

// File: rtl/mac_kbd_host.sv
// Mac Plus keyboard host: issues Model and Test at start-up, then polls with Inquiry.
// It decodes response bytes into key events. A 0x79 keypad prefix is chased with Instant.
// All state advances only on ce=1.
module mac_kbd_host #(
  parameter int unsigned CMD_GAP = 16,
  parameter logic [23:0] TIMEOUT = 24'h500000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic           enable,
  mac_kbd_host_if.master kbd,
  output logic           key_valid,
  output logic [6:0]     key_code,
  output logic           key_up,
  output logic           key_keypad,
  output logic [7:0]     model_id,
  output logic           test_ok,
  output logic           timeout_err
);

  localparam logic [7:0] CmdModel   = 8'h16;
  localparam logic [7:0] CmdTest    = 8'h36;
  localparam logic [7:0] CmdInquiry = 8'h10;
  localparam logic [7:0] CmdInstant = 8'h14;
  localparam logic [7:0] RspNull    = 8'h7b;
  localparam logic [7:0] RspPrefix  = 8'h79;
  localparam logic [7:0] RspTestOk  = 8'h7d;

  localparam int unsigned GapW = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;

  typedef enum logic [1:0] {StGap, StSend, StWait, StIdle} state_e;

  state_e          state_q;
  logic [7:0]      next_cmd_q;
  logic [7:0]      cmd_data_q;
  logic            cmd_strobe_q;
  logic            prefix_q;
  logic [GapW-1:0] gap_cnt_q;
  logic [23:0]     timer_q;

  logic            gap_done;
  logic [23:0]     timer_inc;
  logic            rsp_valid;
  logic [7:0]      rsp_byte;

  assign kbd.cmd_data   = cmd_data_q;
  assign kbd.cmd_strobe = cmd_strobe_q;
  assign rsp_byte       = kbd.rsp_data;

  // Gap completion, saturating timer step, and response qualification.
  always_comb begin
    gap_done  = (32'(gap_cnt_q) + 32'd1) >= CMD_GAP;
    timer_inc = (timer_q == '1) ? timer_q : timer_q + 24'd1;
    // A response that coincides with our own strobe belongs to the previous transaction.
    rsp_valid = kbd.rsp_strobe && !cmd_strobe_q;
  end

  // Transaction sequencer with registered command, event and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StGap;
      next_cmd_q   <= CmdModel;
      cmd_data_q   <= 8'h00;
      cmd_strobe_q <= 1'b0;
      prefix_q     <= 1'b0;
      gap_cnt_q    <= '0;
      timer_q      <= '0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_up       <= 1'b0;
      key_keypad   <= 1'b0;
      model_id     <= 8'h00;
      test_ok      <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (ce) begin
      cmd_strobe_q <= 1'b0;
      key_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      unique case (state_q)
        StGap: begin
          if (!enable) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
          end else if (gap_done) begin
            state_q   <= StSend;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        StIdle: begin
          if (enable) begin
            state_q    <= StGap;
            next_cmd_q <= CmdInquiry;
          end
        end
        StSend: begin
          cmd_data_q   <= next_cmd_q;
          cmd_strobe_q <= 1'b1;
          timer_q      <= '0;
          state_q      <= StWait;
        end
        StWait: begin
          timer_q <= timer_inc;
          if (rsp_valid) begin
            state_q    <= StGap;
            next_cmd_q <= CmdInquiry;
            if (cmd_data_q == CmdModel) begin
              model_id   <= rsp_byte;
              next_cmd_q <= CmdTest;
            end else if (cmd_data_q == CmdTest) begin
              test_ok <= (rsp_byte == RspTestOk);
            end else if (rsp_byte == RspNull) begin
              // A null answer to Instant abandons any pending prefix.
              prefix_q <= 1'b0;
            end else if (rsp_byte == RspPrefix) begin
              if (prefix_q) begin
                prefix_q <= 1'b0;
              end else begin
                // Keypad follow-up goes out immediately, regardless of enable.
                prefix_q   <= 1'b1;
                next_cmd_q <= CmdInstant;
                state_q    <= StSend;
              end
            end else begin
              key_valid  <= 1'b1;
              key_code   <= rsp_byte[6:0];
              key_up     <= rsp_byte[7];
              key_keypad <= prefix_q;
              prefix_q   <= 1'b0;
            end
          end else if (timer_inc == TIMEOUT) begin
            timeout_err <= 1'b1;
            prefix_q    <= 1'b0;
            next_cmd_q  <= CmdModel;
            state_q     <= StGap;
          end
        end
        default: state_q <= StGap;
      endcase
    end
  end

  // The two event pulses are mutually exclusive by construction.
  assert property (@(posedge clk) disable iff (reset) !(key_valid && timeout_err));
  assert property (@(posedge clk) disable iff (reset) !(cmd_strobe_q && key_valid));

endmodule
